// File: rtl/framed_serial_receiver_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg: shared definitions for the framed serial receiver.
//   secded_par_bits(dataW) : number of Hamming parity bits P for a payload
//   secded_data_pos(j)     : codeword index that carries payload bit j
//   rx_status_t            : per-word status {corrected, err}
//   IDLE_BIT/START_BIT/STOP_BIT : serial line levels
// ---------------------------------------------------------------------------
package rx_pkg;

    localparam logic IDLE_BIT  = 1'b0;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef struct packed {
        logic corrected;
        logic err;
    } rx_status_t;

    // Smallest P with 2^P >= dataW + P + 1. Scanning downward leaves the
    // smallest qualifying value in result.
    function automatic int secded_par_bits(input int dataW);
        int result;
        result = 7;
        for (int k = 7; k >= 1; k--) begin
            if ((1 << k) >= dataW + k + 1) begin
                result = k;
            end
        end
        return result;
    endfunction

    // Payload bits occupy the non-power-of-two indices in ascending order.
    function automatic int secded_data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < 64; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j && pos == 0) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/framed_serial_receiver_secded_dec.sv
// ---------------------------------------------------------------------------
// secded_dec: combinational SECDED (extended Hamming) decoder.
//   code          in  CODE_W : received codeword, index i = Hamming position i,
//                              index 0 = overall even parity
//   data          out DATA_W : payload after single-bit correction
//   corrected     out 1      : a single-bit error was found (and fixed)
//   uncorrectable out 1      : double-bit error or impossible syndrome
// ---------------------------------------------------------------------------
module secded_dec
    import rx_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int P      = secded_par_bits(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              corrected,
    output logic              uncorrectable
);

    logic [P-1:0] syndrome;
    logic         parityBad;
    logic         inRange;

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syndrome = syndrome ^ P'(i);
            end
        end
        parityBad = ^code;
        // With a single error the syndrome always names a real bit; a
        // syndrome past the end of the codeword can only come from 3+ errors.
        inRange       = int'(syndrome) < CODE_W;
        corrected     = parityBad && inRange;
        uncorrectable = ((syndrome != '0) && !parityBad) || (parityBad && !inRange);
    end

    // Only payload positions need the flip; a syndrome of 0 with bad parity
    // points at the overall parity bit and leaves the payload untouched.
    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int POS = secded_data_pos(j);
        assign data[j] = code[POS] ^ (parityBad && (syndrome == P'(POS)));
    end

endmodule

// File: rtl/framed_serial_receiver.sv
// ---------------------------------------------------------------------------
// framed_serial_receiver: one-bit-per-clock framed serial receiver with
// optional SECDED decode and a first-word-fall-through output FIFO.
//   clock         in  1      : rising-edge clock
//   reset_n       in  1      : asynchronous active-low reset
//   serialIn      in  1      : serial line (idle low, start 1, stop 0)
//   out_data      out DATA_W : head payload, ERR_WORD if unusable, 0 if empty
//   out_corrected out 1      : head word had a corrected single-bit error
//   out_err       out 1      : head word is unusable
//   out_valid     out 1      : FIFO non-empty
//   out_ready     in  1      : consumer takes the head word
//   overflow      out 1      : sticky, a frame was dropped on a full FIFO
//   overflow_clr  in  1      : synchronous clear of overflow
// ---------------------------------------------------------------------------
module framed_serial_receiver
    import rx_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter bit                ECC_EN     = 1'b1,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] ERR_WORD   = 'h15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              serialIn,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int P       = secded_par_bits(DATA_W);
    localparam int CODE_W  = ECC_EN ? (DATA_W + P + 1) : DATA_W;
    localparam int FRAME_W = CODE_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  bitCnt_p0;
    logic [CODE_W-1:0] shiftReg_p0;
    logic              frameDone;

    // ---- stage p0: start detect and bit shifting --------------------------
    // bitCnt_p0 counts frame bits already taken; the start bit is bit 0, so
    // the stop bit is on the line when the count reaches FRAME_W-1.
    assign frameDone = (state == ST_SHIFT) && (bitCnt_p0 == CNT_W'(FRAME_W - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bitCnt_p0 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (serialIn == START_BIT) begin
                        state     <= ST_SHIFT;
                        bitCnt_p0 <= CNT_W'(1);
                    end
                end
                default: begin
                    if (frameDone) begin
                        state     <= ST_IDLE;
                        bitCnt_p0 <= '0;
                    end else begin
                        bitCnt_p0 <= bitCnt_p0 + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Code bits arrive MSB first, so shifting left lands bit CODE_W-1 at the top.
    always_ff @(posedge clock) begin
        if ((state == ST_SHIFT) && !frameDone) begin
            shiftReg_p0 <= {shiftReg_p0[CODE_W-2:0], serialIn};
        end
    end

    // ---- frame evaluation (combinational, at the stop-bit edge) -----------
    logic [DATA_W-1:0] decData;
    logic              decCorrected;
    logic              decUncorr;
    logic [DATA_W-1:0] wordData;
    rx_status_t        wordStatus;

    if (ECC_EN) begin : g_ecc
        secded_dec #(.DATA_W(DATA_W)) uDec (
            .code          (shiftReg_p0),
            .data          (decData),
            .corrected     (decCorrected),
            .uncorrectable (decUncorr)
        );
    end else begin : g_raw
        assign decData      = shiftReg_p0;
        assign decCorrected = 1'b0;
        assign decUncorr    = 1'b0;
    end

    // The stop bit is still on serialIn at the evaluation edge.
    always_comb begin
        wordStatus.err       = (serialIn != STOP_BIT) || decUncorr;
        wordStatus.corrected = decCorrected && !wordStatus.err;
        wordData             = wordStatus.err ? ERR_WORD : decData;
    end

    // ---- stage p1: output FIFO --------------------------------------------
    logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
    logic [AW:0]        wrPtr;
    logic [AW:0]        rdPtr;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               doPop;
    logic               doPush;
    logic               dropEvent;
    logic [ENTRY_W-1:0] headEntry;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop     = !fifoEmpty && out_ready;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign doPush    = frameDone && (!fifoFull || doPop);
    assign dropEvent = frameDone && fifoFull && !doPop;

    always_ff @(posedge clock) begin
        if (doPush) begin
            fifoMem[wrPtr[AW-1:0]] <= {wordData, wordStatus};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            // A new drop wins over a simultaneous clear.
            if (dropEvent) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head is read straight from storage; outputs are forced to 0 when empty
    // so the storage itself needs no reset.
    assign headEntry     = fifoMem[rdPtr[AW-1:0]];
    assign out_valid     = !fifoEmpty;
    assign out_data      = fifoEmpty ? '0 : headEntry[ENTRY_W-1:2];
    assign out_corrected = !fifoEmpty && headEntry[1];
    assign out_err       = !fifoEmpty && headEntry[0];

endmodule

// File: tb/tb_framed_serial_receiver.sv
// ---------------------------------------------------------------------------
// tb_framed_serial_receiver: bench for framed_serial_receiver.
// Instance A uses the defaults (8-bit payload, SECDED, 4-deep FIFO);
// instance B is raw 16-bit with a 2-deep FIFO.
// ---------------------------------------------------------------------------
module tb_framed_serial_receiver;

    logic        clock;
    logic        reset_n;
    logic        serialA, serialB;
    logic [7:0]  outDataA;
    logic [15:0] outDataB;
    logic        outCorrA, outCorrB;
    logic        outErrA, outErrB;
    logic        outValidA, outValidB;
    logic        outReadyA, outReadyB;
    logic        overflowA, overflowB;
    logic        ovfClrA, ovfClrB;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [31:0] data;
        logic        corr;
        logic        err;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];

    framed_serial_receiver uDutA (
        .clock         (clock),
        .reset_n       (reset_n),
        .serialIn      (serialA),
        .out_data      (outDataA),
        .out_corrected (outCorrA),
        .out_err       (outErrA),
        .out_valid     (outValidA),
        .out_ready     (outReadyA),
        .overflow      (overflowA),
        .overflow_clr  (ovfClrA)
    );

    framed_serial_receiver #(.DATA_W(16), .ECC_EN(1'b0), .FIFO_DEPTH(2)) uDutB (
        .clock         (clock),
        .reset_n       (reset_n),
        .serialIn      (serialB),
        .out_data      (outDataB),
        .out_corrected (outCorrB),
        .out_err       (outErrB),
        .out_valid     (outValidB),
        .out_ready     (outReadyB),
        .overflow      (overflowB),
        .overflow_clr  (ovfClrB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder for the 8-bit payload: data at non-power-of-two
    // positions, each parity bit covers the indices sharing its bit, index 0
    // makes the whole word even.
    function automatic logic [12:0] enc8(input logic [7:0] d);
        logic [12:0] c;
        int          pos[8];
        int          pw[4];
        logic        par;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        pw  = '{1, 2, 4, 8};
        c   = '0;
        for (int j = 0; j < 8; j++) c[pos[j]] = d[j];
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int i = 1; i < 13; i++) begin
                if (((i & pw[k]) != 0) && (i != pw[k])) par = par ^ c[i];
            end
            c[pw[k]] = par;
        end
        c[0] = ^c[12:1];
        return c;
    endfunction

    function automatic exp_t mkExp(input logic [31:0] d, input logic corr, input logic err);
        exp_t e;
        e.data = d;
        e.corr = corr;
        e.err  = err;
        return e;
    endfunction

    // Scoreboards: compare the head word on every accepted handshake.
    always @(negedge clock) begin
        if (reset_n && outValidA && outReadyA) begin
            if (qA.size() == 0) begin
                check("A unexpected word", qA.size(), 1);
            end else begin
                exp_t e;
                e = qA.pop_front();
                check("A data", {24'd0, outDataA}, e.data);
                check("A corrected", outCorrA, e.corr);
                check("A err", outErrA, e.err);
            end
        end
        if (reset_n && outValidB && outReadyB) begin
            if (qB.size() == 0) begin
                check("B unexpected word", qB.size(), 1);
            end else begin
                exp_t e;
                e = qB.pop_front();
                check("B data", {16'd0, outDataB}, e.data);
                check("B corrected", outCorrB, e.corr);
                check("B err", outErrB, e.err);
            end
        end
    end

    task automatic driveBit(input bit selB, input logic b);
        if (selB) serialB = b;
        else      serialA = b;
        @(posedge clock);
        #1;
    endtask

    task automatic sendFrame(input bit selB, input logic [31:0] code, input int codeW,
                             input logic stopBit, input bit popAtStop, input bit chkLat);
        driveBit(selB, 1'b1);
        for (int i = codeW - 1; i >= 0; i--) driveBit(selB, code[i]);
        if (chkLat) check("A valid before stop edge", outValidA, 1'b0);
        if (popAtStop) outReadyB = 1'b1;
        driveBit(selB, stopBit);
        if (popAtStop) outReadyB = 1'b0;
        if (chkLat) check("A valid after stop edge", outValidA, 1'b1);
        if (selB) serialB = 1'b0;
        else      serialA = 1'b0;
    endtask

    task automatic drainA();
        outReadyA = 1'b1;
        for (int i = 0; i < 200 && (qA.size() != 0 || outValidA); i++) begin
            @(posedge clock);
            #1;
        end
        check("A drained", qA.size(), 0);
    endtask

    task automatic drainB();
        outReadyB = 1'b1;
        for (int i = 0; i < 200 && (qB.size() != 0 || outValidB); i++) begin
            @(posedge clock);
            #1;
        end
        check("B drained", qB.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

    initial begin
        logic [12:0] code;

        reset_n   = 1'b0;
        serialA   = 1'b0;
        serialB   = 1'b0;
        outReadyA = 1'b0;
        outReadyB = 1'b0;
        ovfClrA   = 1'b0;
        ovfClrB   = 1'b0;
        idle(3);

        check("reset A out_valid", outValidA, 1'b0);
        check("reset A out_data", outDataA, 8'h00);
        check("reset A out_corrected", outCorrA, 1'b0);
        check("reset A out_err", outErrA, 1'b0);
        check("reset A overflow", overflowA, 1'b0);
        check("reset B out_valid", outValidB, 1'b0);
        check("reset B out_data", outDataB, 16'h0000);
        reset_n = 1'b1;
        idle(2);

        // Clean frame with latency check; consumer not ready until after.
        qA.push_back(mkExp(32'hA5, 1'b0, 1'b0));
        sendFrame(1'b0, {19'd0, enc8(8'hA5)}, 13, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("A head held while not ready", outDataA, 8'hA5);
        drainA();

        // Single-bit errors: a payload position, then the overall parity bit.
        code = enc8(8'h3C);
        code[6] = ~code[6];
        qA.push_back(mkExp(32'h3C, 1'b1, 1'b0));
        sendFrame(1'b0, {19'd0, code}, 13, 1'b0, 1'b0, 1'b0);
        code = enc8(8'h3C);
        code[0] = ~code[0];
        qA.push_back(mkExp(32'h3C, 1'b1, 1'b0));
        sendFrame(1'b0, {19'd0, code}, 13, 1'b0, 1'b0, 1'b0);

        // Double-bit error, then a bad stop bit on a clean code.
        code = enc8(8'h3C);
        code[3]  = ~code[3];
        code[10] = ~code[10];
        qA.push_back(mkExp(32'h15, 1'b0, 1'b1));
        sendFrame(1'b0, {19'd0, code}, 13, 1'b0, 1'b0, 1'b0);
        qA.push_back(mkExp(32'h15, 1'b0, 1'b1));
        sendFrame(1'b0, {19'd0, enc8(8'h77)}, 13, 1'b1, 1'b0, 1'b0);
        drainA();

        // Overflow: four back-to-back frames fill the FIFO, the fifth drops.
        outReadyA = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            qA.push_back(mkExp(i, 1'b0, 1'b0));
            sendFrame(1'b0, {19'd0, enc8(8'(i))}, 13, 1'b0, 1'b0, 1'b0);
        end
        check("A no overflow at exactly full", overflowA, 1'b0);
        sendFrame(1'b0, {19'd0, enc8(8'h05)}, 13, 1'b0, 1'b0, 1'b0);
        check("A overflow after drop", overflowA, 1'b1);
        drainA();
        check("A overflow sticky after drain", overflowA, 1'b1);
        ovfClrA = 1'b1;
        idle(1);
        ovfClrA = 1'b0;
        check("A overflow cleared", overflowA, 1'b0);

        // Clear held through a drop: the drop must win.
        outReadyA = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            qA.push_back(mkExp(i, 1'b0, 1'b0));
            sendFrame(1'b0, {19'd0, enc8(8'(i))}, 13, 1'b0, 1'b0, 1'b0);
        end
        ovfClrA = 1'b1;
        sendFrame(1'b0, {19'd0, enc8(8'h0A)}, 13, 1'b0, 1'b0, 1'b0);
        ovfClrA = 1'b0;
        check("A overflow set wins over clear", overflowA, 1'b1);
        drainA();
        ovfClrA = 1'b1;
        idle(1);
        ovfClrA = 1'b0;

        // Reset in the middle of a frame discards it.
        outReadyA = 1'b0;
        code = enc8(8'hC3);
        driveBit(1'b0, 1'b1);
        for (int i = 12; i >= 7; i--) driveBit(1'b0, code[i]);
        reset_n = 1'b0;
        serialA = 1'b0;
        idle(2);
        check("A valid after mid-frame reset", outValidA, 1'b0);
        check("A overflow after reset", overflowA, 1'b0);
        reset_n = 1'b1;
        idle(1);
        qA.push_back(mkExp(32'h5A, 1'b0, 1'b0));
        sendFrame(1'b0, {19'd0, enc8(8'h5A)}, 13, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("A one word after reset", outValidA, 1'b1);
        drainA();
        check("A empty after single word", outValidA, 1'b0);

        // Raw 16-bit instance with a continuously ready consumer.
        outReadyB = 1'b1;
        qB.push_back(mkExp(32'hBEEF, 1'b0, 1'b0));
        sendFrame(1'b1, 32'hBEEF, 16, 1'b0, 1'b0, 1'b0);
        drainB();
        check("B no overflow streaming", overflowB, 1'b0);

        // Full 2-deep FIFO: push and pop on the same edge keep every word.
        outReadyB = 1'b0;
        qB.push_back(mkExp(32'h1111, 1'b0, 1'b0));
        sendFrame(1'b1, 32'h1111, 16, 1'b0, 1'b0, 1'b0);
        qB.push_back(mkExp(32'h2222, 1'b0, 1'b0));
        sendFrame(1'b1, 32'h2222, 16, 1'b0, 1'b0, 1'b0);
        qB.push_back(mkExp(32'h3333, 1'b0, 1'b0));
        sendFrame(1'b1, 32'h3333, 16, 1'b0, 1'b1, 1'b0);
        check("B no overflow on push+pop when full", overflowB, 1'b0);
        drainB();

        // Raw mode still flags a bad stop bit.
        qB.push_back(mkExp(32'h0015, 1'b0, 1'b1));
        sendFrame(1'b1, 32'h1234, 16, 1'b1, 1'b0, 1'b0);
        drainB();

        idle(4);
        check("A spurious words at end", outValidA, 1'b0);
        check("B spurious words at end", outValidB, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
